// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle for mem_bus_arbiter: two requester ports, the memory side and status.
// The arbiter connects through the slave modport. The requesters and memory connect through master.
interface mem_bus_arbiter_if;
  logic       req0;
  logic       rd0;
  logic       wrt0;
  logic [7:0] addr0;
  logic [7:0] wdat0;
  logic       gnt0;
  logic       req1;
  logic       rd1;
  logic       wrt1;
  logic [7:0] addr1;
  logic [7:0] wdat1;
  logic       gnt1;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic       mem_wrt;
  logic [7:0] mem_wdat;
  logic [7:0] mem_rdat;
  logic [7:0] rdat;
  logic       busy;
  logic       err;

  modport slave (
    input  req0, rd0, wrt0, addr0, wdat0,
    input  req1, rd1, wrt1, addr1, wdat1,
    input  mem_rdat,
    output gnt0, gnt1, mem_addr, mem_rd, mem_wrt, mem_wdat, rdat, busy, err
  );

  modport master (
    output req0, rd0, wrt0, addr0, wdat0,
    output req1, rd1, wrt1, addr1, wdat1,
    output mem_rdat,
    input  gnt0, gnt1, mem_addr, mem_rd, mem_wrt, mem_wdat, rdat, busy, err
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter for the 8-bit memory bus, with a dead TURN cycle between owners.
// Define ARB_PREEMPT_EN to force an owner off the bus after MAX_HOLD cycles while the other requester waits.
module mem_bus_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input logic               clk,
  input logic               rst,
  mem_bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, TURN} state_t;

`ifdef ARB_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state, state_nxt;
  logic       last_owner;
  logic [7:0] hold_cnt;
  logic [7:0] mem_addr_q, mem_wdat_q;
  logic       mem_rd_q, mem_wrt_q, err_q;
  logic       at_limit;
  logic       pick1;
  logic       own_rd, own_wrt;
  logic [7:0] own_addr, own_wdat;

  assign at_limit = (hold_cnt == HOLD_LAST);
  // When both requesters ask, the one that did not own the bus last wins.
  assign pick1    = bus.req1 && (!bus.req0 || !last_owner);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, TURN: begin
        if (pick1)         state_nxt = GRANT1;
        else if (bus.req0) state_nxt = GRANT0;
        else               state_nxt = IDLE;
      end
      GRANT0: if (!bus.req0 || (PREEMPT && bus.req1 && at_limit)) state_nxt = TURN;
      GRANT1: if (!bus.req1 || (PREEMPT && bus.req0 && at_limit)) state_nxt = TURN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    own_rd   = 1'b0;
    own_wrt  = 1'b0;
    own_addr = mem_addr_q;
    own_wdat = mem_wdat_q;
    if (state_nxt == GRANT0) begin
      own_rd   = bus.rd0;
      own_wrt  = bus.wrt0;
      own_addr = bus.addr0;
      own_wdat = bus.wdat0;
    end else if (state_nxt == GRANT1) begin
      own_rd   = bus.rd1;
      own_wrt  = bus.wrt1;
      own_addr = bus.addr1;
      own_wdat = bus.wdat1;
    end
  end

  // The memory side is registered on the same edge as the grant, so the owner's first strobe is visible with gnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      hold_cnt   <= 8'd0;
      mem_addr_q <= 8'd0;
      mem_wdat_q <= 8'd0;
      mem_rd_q   <= 1'b0;
      mem_wrt_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == GRANT0 && state != GRANT0) begin
        last_owner <= 1'b0;
        hold_cnt   <= 8'd0;
      end else if (state_nxt == GRANT1 && state != GRANT1) begin
        last_owner <= 1'b1;
        hold_cnt   <= 8'd0;
      end else if ((state == GRANT0 || state == GRANT1) && hold_cnt != 8'hFF) begin
        hold_cnt <= hold_cnt + 8'd1;
      end
      mem_addr_q <= own_addr;
      mem_wdat_q <= own_wdat;
      mem_rd_q   <= own_rd;
      mem_wrt_q  <= own_wrt && !own_rd;
      if (own_rd && own_wrt) err_q <= 1'b1;
    end
  end

  assign bus.gnt0     = (state == GRANT0);
  assign bus.gnt1     = (state == GRANT1);
  assign bus.busy     = (state != IDLE);
  assign bus.err      = err_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_wdat = mem_wdat_q;
  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_wrt  = mem_wrt_q;
  assign bus.rdat     = bus.mem_rdat;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenarios followed by random traffic, checked against an ownership-level model.
module tb_mem_bus_arbiter;

  localparam int MH = 4;
`ifdef ARB_PREEMPT_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req [2];
  logic       rd  [2];
  logic       wr  [2];
  logic [7:0] addr[2];
  logic [7:0] wdat[2];
  logic [7:0] rdat_in;

  always #5 clk = ~clk;

  mem_bus_arbiter_if bus ();

  assign bus.req0     = req[0];
  assign bus.rd0      = rd[0];
  assign bus.wrt0     = wr[0];
  assign bus.addr0    = addr[0];
  assign bus.wdat0    = wdat[0];
  assign bus.req1     = req[1];
  assign bus.rd1      = rd[1];
  assign bus.wrt1     = wr[1];
  assign bus.addr1    = addr[1];
  assign bus.wdat1    = wdat[1];
  assign bus.mem_rdat = rdat_in;

  mem_bus_arbiter #(.MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: who owns the bus, whether a dead cycle is in progress, and the memory-side image.
  int         m_owner;
  bit         m_turn;
  int         m_last;
  int         m_hold;
  logic       m_rd, m_wr, m_err;
  logic [7:0] m_addr, m_wdat;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelEdge();
    int nxt;
    bit nturn;
    if (rst) begin
      m_owner = -1; m_turn = 0; m_last = 1; m_hold = 0;
      m_rd = 0; m_wr = 0; m_err = 0; m_addr = 8'd0; m_wdat = 8'd0;
      return;
    end
    nturn = 0;
    if (m_owner >= 0) begin
      if (!req[m_owner] || (PRE && req[1 - m_owner] && m_hold == MH - 1)) begin
        nxt = -1;
        nturn = 1;
      end else begin
        nxt = m_owner;
      end
    end else begin
      if (req[0] && req[1]) nxt = 1 - m_last;
      else if (req[0])      nxt = 0;
      else if (req[1])      nxt = 1;
      else                  nxt = -1;
    end
    if (nxt >= 0 && nxt != m_owner) m_hold = 0;
    else if (m_owner >= 0 && m_hold < 255) m_hold++;
    if (nxt >= 0) begin
      m_last = nxt;
      m_addr = addr[nxt];
      m_wdat = wdat[nxt];
      m_rd   = rd[nxt];
      m_wr   = wr[nxt] && !rd[nxt];
      if (rd[nxt] && wr[nxt]) m_err = 1;
    end else begin
      m_rd = 0;
      m_wr = 0;
    end
    m_owner = nxt;
    m_turn  = nturn;
  endtask

  task automatic checkOutput();
    chk("gnt0",     8'(bus.gnt0),    8'(m_owner == 0));
    chk("gnt1",     8'(bus.gnt1),    8'(m_owner == 1));
    chk("busy",     8'(bus.busy),    8'(m_owner >= 0 || m_turn));
    chk("err",      8'(bus.err),     8'(m_err));
    chk("mem_rd",   8'(bus.mem_rd),  8'(m_rd));
    chk("mem_wrt",  8'(bus.mem_wrt), 8'(m_wr));
    chk("mem_addr", bus.mem_addr,    m_addr);
    chk("mem_wdat", bus.mem_wdat,    m_wdat);
    chk("rdat",     bus.rdat,        rdat_in);
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(
    input logic r,
    input logic q0, input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
    input logic q1, input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1
  );
    rst = r;
    req[0] = q0; rd[0] = r0; wr[0] = w0; addr[0] = a0; wdat[0] = d0;
    req[1] = q1; rd[1] = r1; wr[1] = w1; addr[1] = a1; wdat[1] = d1;
    rdat_in = 8'($urandom_range(0, 255));
    tick();
  endtask

  initial begin
    $display("[TB] start, preemption %0d, MAX_HOLD %0d", PRE, MH);

    // Reset state
    applyStimulus(1, 0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00);
    applyStimulus(1, 0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00);
    chk("rst_gnt0", 8'(bus.gnt0), 8'd0);
    chk("rst_busy", 8'(bus.busy), 8'd0);
    chk("rst_addr", bus.mem_addr, 8'h00);

    // Processor read from idle
    applyStimulus(0, 1,1,0,8'h10,8'h00, 0,0,0,8'h00,8'h00);
    chk("rd0_gnt0", 8'(bus.gnt0),   8'd1);
    chk("rd0_mrd",  8'(bus.mem_rd), 8'd1);
    chk("rd0_addr", bus.mem_addr,   8'h10);
    chk("rd0_gnt1", 8'(bus.gnt1),   8'd0);
    chk("rd0_busy", 8'(bus.busy),   8'd1);

    // Tie from reset: processor first, TURN, then host
    applyStimulus(1, 0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00);
    applyStimulus(0, 1,0,0,8'h01,8'h00, 1,0,0,8'h02,8'h00);
    chk("tie_gnt0", 8'(bus.gnt0), 8'd1);
    applyStimulus(0, 0,0,0,8'h01,8'h00, 1,0,0,8'h02,8'h00);
    chk("turn_gnt0", 8'(bus.gnt0), 8'd0);
    chk("turn_gnt1", 8'(bus.gnt1), 8'd0);
    chk("turn_busy", 8'(bus.busy), 8'd1);
    applyStimulus(0, 0,0,0,8'h01,8'h00, 1,0,0,8'h02,8'h00);
    chk("tie_gnt1", 8'(bus.gnt1), 8'd1);

    // Host write while processor strobes are ignored
    applyStimulus(0, 0,1,1,8'h55,8'h66, 1,0,1,8'h3F,8'hA5);
    chk("hw_wrt",  8'(bus.mem_wrt), 8'd1);
    chk("hw_addr", bus.mem_addr,    8'h3F);
    chk("hw_wdat", bus.mem_wdat,    8'hA5);
    chk("hw_err",  8'(bus.err),     8'd0);

    // Owner drives rd and wrt together
    applyStimulus(0, 0,0,0,8'h00,8'h00, 0,0,0,8'h3F,8'hA5);
    applyStimulus(0, 1,1,1,8'h20,8'h77, 0,0,0,8'h00,8'h00);
    chk("pe_rd",  8'(bus.mem_rd),  8'd1);
    chk("pe_wrt", 8'(bus.mem_wrt), 8'd0);
    chk("pe_err", 8'(bus.err),     8'd1);
    applyStimulus(0, 0,0,0,8'h20,8'h77, 0,0,0,8'h00,8'h00);
    applyStimulus(0, 0,0,0,8'h20,8'h77, 0,0,0,8'h00,8'h00);
    chk("pe_sticky", 8'(bus.err), 8'd1);
    applyStimulus(1, 0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00);
    chk("pe_clear", 8'(bus.err), 8'd0);

    // Long hold by processor while host waits
    applyStimulus(0, 1,0,0,8'h30,8'h00, 0,0,0,8'h00,8'h00);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1,0,0,8'h30,8'h00, 1,0,0,8'h40,8'h00);
    chk("hold4_gnt0", 8'(bus.gnt0), 8'd1);
    applyStimulus(0, 1,0,0,8'h30,8'h00, 1,0,0,8'h40,8'h00);
    chk("hold5_gnt0", 8'(bus.gnt0), PRE ? 8'd0 : 8'd1);
    applyStimulus(0, 1,0,0,8'h30,8'h00, 1,0,0,8'h40,8'h00);
    chk("hold6_gnt1", 8'(bus.gnt1), PRE ? 8'd1 : 8'd0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1,0,0,8'h30,8'h00, 1,0,0,8'h40,8'h00);

    // Reset during a host write
    applyStimulus(1, 0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00);
    applyStimulus(0, 0,0,0,8'h00,8'h00, 1,1,1,8'h44,8'h99);
    chk("rw_err", 8'(bus.err), 8'd1);
    applyStimulus(1, 0,0,0,8'h00,8'h00, 1,0,1,8'h45,8'h98);
    chk("rst_mid_gnt1", 8'(bus.gnt1),    8'd0);
    chk("rst_mid_wrt",  8'(bus.mem_wrt), 8'd0);
    chk("rst_mid_busy", 8'(bus.busy),    8'd0);
    chk("rst_mid_err",  8'(bus.err),     8'd0);

    // Random traffic with sticky requests and occasional reset
    for (int i = 0; i < 800; i++) begin
      logic q0, q1;
      q0 = ($urandom_range(0, 5) == 0) ? !req[0] : req[0];
      q1 = ($urandom_range(0, 5) == 0) ? !req[1] : req[1];
      applyStimulus(($urandom_range(0, 59) == 0),
                    q0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                    q1, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
